// File: rtl/game_ctrl_sequencer.sv
// Control-input sequencer for the game core: merges and debounces flap/restart
// requests, then drives the core's active-low button and reset via HOLD / WAIT_REL / RUN.
module game_ctrl_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned RESET_HOLD_CYCLES = 1024,
  parameter int unsigned MIN_PRESS_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  key_n,
  input  logic [15:0] joy,
  output logic        core_button,
  output logic        core_reset_n,
  output logic [1:0]  state
);

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW  = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned SW  = $clog2(MIN_PRESS_CYCLES + 1);
  // Released level per channel: {joy[5], joy[4], key_n[1], key_n[0]}
  localparam logic [NCH-1:0] IDLE_LVL = 4'b0011;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  logic [NCH-1:0]         raw_c;
  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [NCH-1:0]         deb_q, deb_d;
  logic [NCH-1:0][DW-1:0] dcnt_q, dcnt_d;

  logic          flap_req_c, restart_req_c;
  logic          flap_rise_c, restart_rise_c;
  logic          flap_req_q, flap_req_d;
  logic          restart_req_q, restart_req_d;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          core_button_q, core_button_d;
  logic          core_reset_n_q, core_reset_n_d;

  logic          unused_joy;

  assign raw_c      = {joy[5], joy[4], key_n[1], key_n[0]};
  assign unused_joy = ^{joy[15:6], joy[3:0]};

  // Two-stage synchronizer per channel
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
  end

  // Debouncer: deb follows sync only after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i]  = ~deb_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  assign flap_req_c     = ~deb_q[0] | deb_q[2];
  assign restart_req_c  = ~deb_q[1] | deb_q[3];
  assign flap_rise_c    = flap_req_c & ~flap_req_q;
  assign restart_rise_c = restart_req_c & ~restart_req_q;

  always_comb begin
    flap_req_d    = flap_req_c;
    restart_req_d = restart_req_c;
  end

  // Sequencer next-state and registered output values
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stretch_d      = stretch_q;
    core_button_d  = 1'b1;
    core_reset_n_d = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_REL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!flap_req_c && !restart_req_c) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (restart_rise_c) begin
          // Restart wins over a simultaneous flap edge
          state_d   = ST_HOLD;
          cnt_d     = '0;
          stretch_d = '0;
        end else begin
          if (flap_rise_c) begin
            stretch_d = SW'(MIN_PRESS_CYCLES);
          end else if (stretch_q != '0) begin
            stretch_d = stretch_q - SW'(1);
          end
          core_button_d = ~(flap_req_c | (stretch_d != '0));
        end
      end
      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        stretch_d = '0;
      end
    endcase
    core_reset_n_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= IDLE_LVL;
      sync2_q       <= IDLE_LVL;
      deb_q         <= IDLE_LVL;
      dcnt_q        <= '0;
      flap_req_q    <= 1'b0;
      restart_req_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      dcnt_q        <= dcnt_d;
      flap_req_q    <= flap_req_d;
      restart_req_q <= restart_req_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      stretch_q      <= '0;
      core_button_q  <= 1'b1;
      core_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stretch_q      <= stretch_d;
      core_button_q  <= core_button_d;
      core_reset_n_q <= core_reset_n_d;
    end
  end

  assign core_button  = core_button_q;
  assign core_reset_n = core_reset_n_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_ctrl_sequencer.sv
// Bench for game_ctrl_sequencer: spec-level reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and pulse widths.
module tb_game_ctrl_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int MINP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  key_n = 2'b11;
  logic [15:0] joy = '0;
  logic        core_button;
  logic        core_reset_n;
  logic [1:0]  state;

  int nerr = 0;
  int nchk = 0;

  game_ctrl_sequencer #(
    .DEBOUNCE_CYCLES  (DEB),
    .RESET_HOLD_CYCLES(HOLD),
    .MIN_PRESS_CYCLES (MINP)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .key_n       (key_n),
    .joy         (joy),
    .core_button (core_button),
    .core_reset_n(core_reset_n),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Reference model state: sync stages, per-channel history of synced samples, phase
  logic [3:0]     m_s1, m_s2, m_deb;
  logic [DEB-1:0] m_hist [4];
  logic           m_pf, m_pr, m_btn, m_rstn;
  int             m_phase, m_elapsed, m_stretch;

  task automatic model_reset();
    m_s1 = 4'b0011; m_s2 = 4'b0011; m_deb = 4'b0011;
    for (int i = 0; i < 4; i++) m_hist[i] = {DEB{m_deb[i]}};
    m_pf = 1'b0; m_pr = 1'b0; m_btn = 1'b1; m_rstn = 1'b0;
    m_phase = 0; m_elapsed = 0; m_stretch = 0;
  endtask

  task automatic model_tick();
    logic flap, rs, fr, rr;
    if (rst) begin
      model_reset();
      return;
    end
    flap = !m_deb[0] || m_deb[2];
    rs   = !m_deb[1] || m_deb[3];
    fr   = flap && !m_pf;
    rr   = rs && !m_pr;
    case (m_phase)
      0: begin
        m_elapsed++;
        if (m_elapsed == HOLD) begin m_phase = 1; m_elapsed = 0; end
      end
      1: if (!flap && !rs) m_phase = 2;
      default: begin
        if (rr) begin
          m_phase = 0; m_elapsed = 0; m_stretch = 0;
        end else if (fr) begin
          m_stretch = MINP;
        end else if (m_stretch > 0) begin
          m_stretch--;
        end
      end
    endcase
    m_btn  = (m_phase == 2) ? !(flap || m_stretch > 0) : 1'b1;
    m_rstn = (m_phase != 0);
    m_pf = flap;
    m_pr = rs;
    // A debounced level flips once the last DEB synced samples all disagree with it
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
      if (m_hist[i] == {DEB{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
    end
    m_s2 = m_s1;
    m_s1 = {joy[5], joy[4], key_n[1], key_n[0]};
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model with the DUT, then compare all outputs away from the edge
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check("model_button", core_button, m_btn);
    check("model_reset_n", core_reset_n, m_rstn);
    check("model_state", state, m_phase);
  endtask

  int  o_first, o_low, o_falls;
  logic o_prev;

  task automatic obs_clear(input logic sig);
    o_first = -1; o_low = 0; o_falls = 0; o_prev = sig;
  endtask

  task automatic obs(input int k, input logic sig);
    if (!sig) begin
      o_low++;
      if (o_first < 0) o_first = k;
    end
    if (o_prev && !sig) o_falls++;
    o_prev = sig;
  endtask

  task automatic count_reset_low(input string name);
    int n;
    n = 0;
    while (core_reset_n === 1'b0 && n < 50) begin
      n++;
      step();
    end
    check(name, n, HOLD);
  endtask

  initial begin
    int run_k, st7, st56;

    // 1. reset values, then HOLD -> WAIT_REL -> RUN
    #1 rst = 1'b1;
    model_reset();
    repeat (3) step();
    check("rst_button", core_button, 1);
    check("rst_reset_n", core_reset_n, 0);
    check("rst_state", state, 0);
    rst = 1'b0;
    count_reset_low("t1_hold_len");
    check("t1_wait_rel", state, 1);
    step();
    check("t1_run", state, 2);
    repeat (3) step();

    // 2a. 3-cycle glitch on key_n[0] is filtered
    obs_clear(core_button);
    key_n[0] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 3) key_n[0] = 1'b1;
      obs(k, core_button);
    end
    check("t2_glitch_low", o_low, 0);

    // 2b. 20-cycle press: latency 2+4+1, low width follows the press
    obs_clear(core_button);
    key_n[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 20) key_n[0] = 1'b1;
      obs(k, core_button);
    end
    check("t2_latency", o_first, 7);
    check("t2_width", o_low, 20);
    repeat (5) step();

    // 3a. short joy[4] tap is stretched to MIN_PRESS_CYCLES
    obs_clear(core_button);
    joy[4] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 5) joy[4] = 1'b0;
      obs(k, core_button);
    end
    check("t3_tap_latency", o_first, 7);
    check("t3_tap_width", o_low, MINP);

    // 3b. overlapping joy[4] and key_n[0] give one continuous pulse
    obs_clear(core_button);
    joy[4] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 3) key_n[0] = 1'b0;
      if (k == 10) joy[4] = 1'b0;
      if (k == 15) key_n[0] = 1'b1;
      obs(k, core_button);
    end
    check("t3_overlap_pulses", o_falls, 1);
    check("t3_overlap_width", o_low, 15);
    repeat (5) step();

    // 4a. joy[5] pulse -> one 8-cycle reset, WAIT_REL, then RUN
    obs_clear(core_reset_n);
    joy[5] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 6) joy[5] = 1'b0;
      obs(k, core_reset_n);
      if (k == 15) check("t4_wait_rel", state, 1);
      if (k == 16) check("t4_run", state, 2);
    end
    check("t4_reset_latency", o_first, 7);
    check("t4_reset_width", o_low, HOLD);

    // 4b. restart held 50 cycles: single reset, RUN only after release
    obs_clear(core_reset_n);
    run_k = -1;
    st56 = -1;
    joy[5] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 50) joy[5] = 1'b0;
      obs(k, core_reset_n);
      if (k == 56) st56 = state;
      if (k > 8 && run_k < 0 && state == 2'd2) run_k = k;
    end
    check("t4_held_pulses", o_falls, 1);
    check("t4_held_width", o_low, HOLD);
    check("t4_held_waiting", st56, 1);
    check("t4_held_run_at", run_k, 57);

    // 5. flap and restart in the same cycle: restart wins, no button press
    obs_clear(core_button);
    run_k = -1;
    st7 = -1;
    key_n = 2'b00;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k == 10) key_n = 2'b11;
      obs(k, core_button);
      if (k == 7) st7 = state;
      if (k > 8 && run_k < 0 && state == 2'd2) run_k = k;
    end
    check("t5_button_low", o_low, 0);
    check("t5_hold", st7, 0);
    check("t5_run_at", run_k, 17);

    // 6. async reset during an active stretch, then a full HOLD again
    key_n[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 5) key_n[0] = 1'b1;
    end
    check("t6_pre_button", core_button, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_button", core_button, 1);
    check("t6_async_reset_n", core_reset_n, 0);
    check("t6_async_state", state, 0);
    repeat (3) step();
    rst = 1'b0;
    count_reset_low("t6_hold_len");
    repeat (3) step();
    check("t6_run", state, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
